// File: rtl/mips_bus_pkg.sv
// Shared types and defaults for the CPU-to-memory Avalon-MM bridge.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bridge_state_t;

  localparam logic [31:0] DEF_ERR_READDATA   = 32'h0000_0000;
  localparam int          DEF_TIMEOUT_CYCLES = 256;
  localparam int          TMO_W              = 16;

endpackage

// File: rtl/mips_bus_timeout.sv
// Loadable up-counter with a terminal-count flag, used to bound memory stalls.
module mips_bus_timeout #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == i_term);

endmodule

// File: rtl/mips_avalon_bridge.sv
// Registered Avalon-MM bridge: captures a CPU request, replays it to memory
// with waitrequest handshaking, and rejects misaligned/illegal/stalled transfers.
module mips_avalon_bridge
  import mips_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] ERR_READDATA   = DEF_ERR_READDATA
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] s_address,
  input  logic [3:0]  s_byteenable,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic        s_waitrequest,
  output logic [31:0] s_readdata,
  output logic [31:0] m_address,
  output logic [3:0]  m_byteenable,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        err_misalign,
  output logic        err_illegal,
  output logic        err_timeout,
  output logic [31:0] txn_count
);

  localparam logic [TMO_W-1:0] TMO_TERM = TMO_W'(TIMEOUT_CYCLES - 1);

  bridge_state_t r_state;
  logic [31:0]   r_address;
  logic [3:0]    r_byteenable;
  logic [31:0]   r_writedata;
  logic [31:0]   r_readdata;
  logic          r_m_read;
  logic          r_m_write;
  logic          r_err_misalign;
  logic          r_err_illegal;
  logic          r_err_timeout;
  logic [31:0]   r_txn_count;

  logic w_req;
  logic w_illegal;
  logic w_misalign;
  logic w_tmo_tc;

  assign w_req      = s_read | s_write;
  assign w_illegal  = s_read & s_write;
  assign w_misalign = (s_address[1:0] != 2'b00);

  // Counter is held cleared in IDLE so it starts at zero on the first BUSY cycle.
  mips_bus_timeout #(
    .W (TMO_W)
  ) u_timeout (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (r_state == IDLE),
    .i_load_val ('0),
    .i_en       (r_state == BUSY),
    .i_term     (TMO_TERM),
    .o_tc       (w_tmo_tc)
  );

  always_comb begin
    s_waitrequest = 1'b0;
    case (r_state)
      IDLE:    s_waitrequest = w_req;
      BUSY:    s_waitrequest = 1'b1;
      default: s_waitrequest = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_address      <= '0;
      r_byteenable   <= '0;
      r_writedata    <= '0;
      r_readdata     <= '0;
      r_m_read       <= 1'b0;
      r_m_write      <= 1'b0;
      r_err_misalign <= 1'b0;
      r_err_illegal  <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_txn_count    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_address    <= s_address;
            r_byteenable <= s_byteenable;
            r_writedata  <= s_writedata;
            if (w_illegal || w_misalign) begin
              if (w_illegal)  r_err_illegal  <= 1'b1;
              if (w_misalign) r_err_misalign <= 1'b1;
              r_readdata <= ERR_READDATA;
              r_state    <= DONE;
            end else begin
              r_m_read  <= s_read;
              r_m_write <= s_write;
              r_state   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!m_waitrequest) begin
            if (r_m_read) r_readdata <= m_readdata;
            r_txn_count <= r_txn_count + 32'd1;
            r_m_read    <= 1'b0;
            r_m_write   <= 1'b0;
            r_state     <= DONE;
          end else if (w_tmo_tc) begin
            // Abandoned transfer: not counted, CPU gets the error pattern.
            r_err_timeout <= 1'b1;
            r_readdata    <= ERR_READDATA;
            r_m_read      <= 1'b0;
            r_m_write     <= 1'b0;
            r_state       <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_readdata   = r_readdata;
  assign m_address    = r_address;
  assign m_byteenable = r_byteenable;
  assign m_writedata  = r_writedata;
  assign m_read       = r_m_read;
  assign m_write      = r_m_write;
  assign err_misalign = r_err_misalign;
  assign err_illegal  = r_err_illegal;
  assign err_timeout  = r_err_timeout;
  assign txn_count    = r_txn_count;

endmodule

// File: tb/tb_mips_avalon_bridge.sv
// Scoreboard bench for mips_avalon_bridge with a small wait-state memory model.
module tb_mips_avalon_bridge;

  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] s_address = '0;
  logic [3:0]  s_byteenable = '0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = '0;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic [31:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        err_misalign;
  logic        err_illegal;
  logic        err_timeout;
  logic [31:0] txn_count;

  mips_avalon_bridge #(
    .TIMEOUT_CYCLES (8),
    .ERR_READDATA   (ERRV)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_address     (s_address),
    .s_byteenable  (s_byteenable),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_writedata   (s_writedata),
    .s_waitrequest (s_waitrequest),
    .s_readdata    (s_readdata),
    .m_address     (m_address),
    .m_byteenable  (m_byteenable),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .m_readdata    (m_readdata),
    .err_misalign  (err_misalign),
    .err_illegal   (err_illegal),
    .err_timeout   (err_timeout),
    .txn_count     (txn_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory model: word slot chosen by address bits [14:12]; wait_n wait cycles per access.
  logic [31:0] mem [0:7];
  int          wait_n = 0;
  logic        stuck = 1'b0;
  int          wcnt = 0;

  assign m_waitrequest = stuck || (wcnt < wait_n);
  always_comb m_readdata = mem[m_address[14:12]];

  always @(posedge clk) begin
    if ((m_read || m_write) && m_waitrequest) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (m_write && !m_waitrequest) begin
      for (int b = 0; b < 4; b++)
        if (m_byteenable[b]) mem[m_address[14:12]][8*b +: 8] <= m_writedata[8*b +: 8];
    end
  end

  // Bus activity and stability tracking.
  int          busy_n = 0;
  logic        prev_busy = 1'b0;
  logic        unstable = 1'b0;
  logic [31:0] f_addr, f_wd;
  logic [3:0]  f_be;
  logic        f_rd, f_wr;

  always @(negedge clk) begin
    if (m_read || m_write) begin
      if (!prev_busy) begin
        f_addr = m_address; f_wd = m_writedata; f_be = m_byteenable;
        f_rd = m_read; f_wr = m_write;
      end else if (m_address !== f_addr || m_writedata !== f_wd || m_byteenable !== f_be ||
                   m_read !== f_rd || m_write !== f_wr) begin
        unstable = 1'b1;
      end
      busy_n++;
    end
    prev_busy = m_read || m_write;
  end

  // Scoreboard.
  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;
  exp_t sb[$];
  int   mon_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && (s_read || s_write)) begin
      mon_cyc++;
      if (!s_waitrequest) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_completion actual=%h required=none", s_readdata);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_data"}, s_readdata, e.data);
          chk({e.name, "_latency"}, mon_cyc, e.cyc);
        end
        mon_cyc = 0;
      end
    end else begin
      mon_cyc = 0;
    end
  end

  task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input int exp_cyc, input string name);
    exp_t e;
    int   n;
    e.data = exp_data; e.cyc = exp_cyc; e.name = name;
    sb.push_back(e);
    s_read = rd; s_write = wr; s_address = addr; s_byteenable = be; s_writedata = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (s_waitrequest && n < 40);
    if (s_waitrequest) begin
      checks++; failures++;
      $display("FAIL %s_handshake actual=stalled required=done_within_40", name);
    end
    @(posedge clk);
    #1;
    s_read = 1'b0; s_write = 1'b0;
  endtask

  int b0;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    mem[0] = 32'h1234_5678;
    #2;
    chk("rst_ctrl", {29'd0, m_read, m_write, s_waitrequest}, 32'd0);
    chk("rst_flags", {29'd0, err_misalign, err_illegal, err_timeout}, 32'd0);
    chk("rst_readdata", s_readdata, 32'd0);
    chk("rst_maddr", m_address, 32'd0);
    chk("rst_txn", txn_count, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    xfer(1'b1, 1'b0, 32'hBFC0_0000, 4'hF, 32'd0, 32'h1234_5678, 3, "read_boot");
    chk("read_boot_txn", txn_count, 32'd1);

    wait_n = 2; b0 = busy_n; unstable = 1'b0;
    xfer(1'b0, 1'b1, 32'h0000_1000, 4'b0011, 32'hCAFE_F00D, 32'h1234_5678, 5, "write_wait2");
    chk("write_busy_cycles", busy_n - b0, 32'd3);
    chk("write_stable", {31'd0, unstable}, 32'd0);
    chk("write_maddr", f_addr, 32'h0000_1000);
    chk("write_mdata", f_wd, 32'hCAFE_F00D);
    chk("write_mbe_op", {26'd0, f_be, f_rd, f_wr}, {26'd0, 4'b0011, 1'b0, 1'b1});
    chk("write_txn", txn_count, 32'd2);
    wait_n = 0;

    xfer(1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'd0, 32'h0000_F00D, 3, "read_back");

    b0 = busy_n;
    xfer(1'b1, 1'b0, 32'h0000_1002, 4'hF, 32'd0, ERRV, 2, "misalign");
    chk("misalign_no_mem", busy_n - b0, 32'd0);
    chk("misalign_flag", {29'd0, err_misalign, err_illegal, err_timeout}, 32'd4);
    chk("misalign_txn", txn_count, 32'd3);

    stuck = 1'b1; b0 = busy_n;
    xfer(1'b1, 1'b0, 32'h0000_2000, 4'hF, 32'd0, ERRV, 10, "timeout");
    chk("timeout_busy_cycles", busy_n - b0, 32'd8);
    chk("timeout_flag", {31'd0, err_timeout}, 32'd1);
    chk("timeout_txn", txn_count, 32'd3);
    chk("timeout_mread_dropped", {31'd0, m_read}, 32'd0);
    stuck = 1'b0;

    xfer(1'b1, 1'b0, 32'hBFC0_0000, 4'hF, 32'd0, 32'h1234_5678, 3, "read_after_tmo");
    chk("read_after_tmo_txn", txn_count, 32'd4);

    b0 = busy_n;
    xfer(1'b1, 1'b1, 32'h0000_3000, 4'hF, 32'h5555_5555, ERRV, 2, "illegal");
    chk("illegal_no_mem", busy_n - b0, 32'd0);
    chk("illegal_flags", {29'd0, err_misalign, err_illegal, err_timeout}, 32'd7);

    xfer(1'b0, 1'b1, 32'h0000_4000, 4'hF, 32'hAABB_CCDD, ERRV, 3, "b2b_write");
    xfer(1'b1, 1'b0, 32'h0000_4000, 4'hF, 32'd0, 32'hAABB_CCDD, 3, "b2b_read");
    chk("b2b_txn", txn_count, 32'd6);

    // Reset in the middle of a stalled read.
    stuck = 1'b1;
    s_read = 1'b1; s_address = 32'h0000_5000; s_byteenable = 4'hF;
    repeat (2) @(posedge clk);
    #2;
    chk("midbusy_mread_high", {31'd0, m_read}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midbusy_mread_async", {31'd0, m_read}, 32'd0);
    chk("midbusy_waitreq", {31'd0, s_waitrequest}, 32'd1);
    chk("midbusy_flags", {29'd0, err_misalign, err_illegal, err_timeout}, 32'd0);
    chk("midbusy_txn", txn_count, 32'd0);
    chk("midbusy_readdata", s_readdata, 32'd0);
    chk("midbusy_maddr_be", {m_address[27:0], m_byteenable}, 32'd0);
    chk("midbusy_mwdata", m_writedata, 32'd0);
    s_read = 1'b0; stuck = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
